// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory target for the MEM stage.
// Each accepted request spends WAIT_STATES cycles in WAIT, then one cycle in
// RESP where Ack pulses. Malformed requests skip the array and answer with Error.
//
// Handshake: the requester raises MemoryRead or MemoryWrite and holds the
// request, Address and WriteData while Stall=1. The access is complete in the
// cycle where Ack=1; the requester drops or changes its request on the clock
// edge that ends that cycle. ReadData and Error are valid only while Ack=1.
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Ack,
    output logic        Error,
    output logic [7:0]  ErrorCount,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [31:0]             mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    req;
    logic                    bad;
    logic                    last_wait;
    logic                    mem_we;
    logic                    unused_addr_bits;

    // Upper address bits alias onto the array and are deliberately ignored.
    assign word_idx         = Address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^Address[31:ADDR_WIDTH+2];

    assign req       = MemoryRead | MemoryWrite;
    assign bad       = (MemoryRead & MemoryWrite) | (Address[1:0] != 2'b00);
    assign last_wait = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we    = last_wait && MemoryWrite;

    // Next-state, wait counter, read data and error bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bad) begin
                        state_d = ST_RESP;
                        error_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    // Inputs are re-sampled here; a write wins if both are seen.
                    if (MemoryRead && !MemoryWrite) begin
                        rdata_d = mem[word_idx];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                error_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                error_d = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset abandons any access still in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'd0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Word array commit on the WAIT->RESP edge; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[word_idx] <= WriteData;
        end
    end

    assign Stall      = Reset & (((state_q == ST_IDLE) & req) | (state_q == ST_WAIT));
    assign Ack        = (state_q == ST_RESP);
    assign Error      = error_q;
    assign ReadData   = rdata_q;
    assign ErrorCount = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: vector table plus hand sequences for reset,
// mid-access reset and error-counter saturation, with a response scoreboard.
module tb_data_memory_responder;

    localparam int WS = 2;
    localparam int W  = 49;   // {err, stall_cycles[7:0], err_cnt[7:0], rdata[31:0]}

    logic        clk;
    logic        rst_n;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        stall;
    logic        ack;
    logic        error;
    logic [7:0]  error_count;
    logic [1:0]  dbg_state;

    int n_pass;
    int n_total;

    logic [W-1:0] exp_q[$];
    logic [7:0]   errcnt_m;
    logic [31:0]  last_rd_m;
    logic [31:0]  mem_m [0:7];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];

    data_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
        .CLK        (clk),
        .Reset      (rst_n),
        .MemoryRead (mem_rd),
        .MemoryWrite(mem_wr),
        .Address    (addr),
        .WriteData  (wdata),
        .ReadData   (read_data),
        .Stall      (stall),
        .Ack        (ack),
        .Error      (error),
        .ErrorCount (error_count),
        .dbg_state  (dbg_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one request, hold it through Stall, score the Ack cycle, then drop it.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp_rdata);
        logic         is_bad;
        logic [W-1:0] e;
        int           stalls;
        bit           got;
        is_bad = (rd & wr) | (a[1:0] != 2'b00);
        if (is_bad) begin
            if (errcnt_m != 8'hFF) errcnt_m = errcnt_m + 8'd1;
        end else if (rd) begin
            last_rd_m = exp_rdata;
        end
        exp_q.push_back({is_bad, (is_bad ? 8'd1 : 8'(WS + 1)), errcnt_m, last_rd_m});
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        stalls = 0;
        got    = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ack) got = 1;
            else if (stall) stalls++;
        end
        e = exp_q.pop_front();
        if (got) begin
            check("stall_cycles", 32'(stalls), 32'(e[47:40]));
            check("error",        32'(error),  32'(e[48]));
            check("read_data",    read_data,   e[31:0]);
            check("error_count",  32'(error_count), 32'(e[39:32]));
        end else begin
            n_total++;
            $display("FAIL ack_timeout: got no Ack after 40 cycles, addr 0x%0h required Ack", a);
        end
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        errcnt_m = 8'd0; last_rd_m = 32'd0;
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h13,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h20,  32'h12345678, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h20,  32'hBAD0BAD0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h12345678};
        vecs[6]  = '{1'b0, 1'b1, 32'h22,  32'h0000FFFF, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h12345678};
        vecs[8]  = '{1'b0, 1'b1, 32'h0,   32'h11,       32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h400, 32'h22,       32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h22};
        vecs[11] = '{1'b0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        32'hA5A5A5A5};
        vecs[13] = '{1'b0, 1'b1, 32'h8,   32'h77,       32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h77};

        // Reset held with a read request pending: nothing may respond.
        rst_n = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h10; wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_stall", 32'(stall), 32'h0);
            check("reset_ack",   32'(ack),   32'h0);
        end
        check("reset_read_data",   read_data,         32'h0);
        check("reset_error",       32'(error),        32'h0);
        check("reset_error_count", 32'(error_count),  32'h0);
        check("reset_state",       32'(dbg_state),    32'h0);
        mem_rd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rdata);
        end

        // Reset during WAIT of a write to 0x8: the old 0x77 must survive.
        @(posedge clk); #1;
        mem_wr = 1'b1; addr = 32'h8; wdata = 32'h55;
        @(negedge clk);
        check("midrst_idle_stall", 32'(stall), 32'h1);
        @(negedge clk);
        check("midrst_in_wait", 32'(dbg_state), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_stall_low", 32'(stall),       32'h0);
        check("midrst_state",     32'(dbg_state),   32'h0);
        check("midrst_read_data", read_data,        32'h0);
        mem_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        errcnt_m = 8'd0; last_rd_m = 32'd0;
        run_access(1'b1, 1'b0, 32'h8, 32'h0, 32'h77);

        // 256 rejected requests: the counter must stop at 255.
        for (int i = 0; i < 256; i++) begin
            if ((i % 2) == 0)
                run_access(1'b1, 1'b0, {22'h0, 8'(i), 2'($urandom_range(1, 3))}, 32'h0, 32'h0);
            else
                run_access(1'b1, 1'b1, {22'h0, 8'(i), 2'b00}, 32'(i), 32'h0);
        end
        check("error_count_saturated", 32'(error_count), 32'hFF);

        // Random traffic over 8 words at 0x100 checked against a bench memory model.
        for (int i = 0; i < 8; i++) begin
            mem_m[i] = $urandom;
            run_access(1'b0, 1'b1, 32'h100 + 32'(i * 4), mem_m[i], 32'h0);
        end
        for (int i = 0; i < 24; i++) begin
            int k;
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                run_access(1'b1, 1'b0, 32'h100 + 32'(k * 4), 32'h0, mem_m[k]);
            end else begin
                mem_m[k] = $urandom;
                run_access(1'b0, 1'b1, 32'h100 + 32'(k * 4), mem_m[k], 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
